// File: rtl/tff_ctrl_pkg.sv
// Shared opcodes, FSM states and START operand layout for the T-flip-flop
// counter controller.
package tff_ctrl_pkg;

    localparam logic [1:0] OP_SET_MOD   = 2'b00;
    localparam logic [1:0] OP_SET_COUNT = 2'b01;
    localparam logic [1:0] OP_START     = 2'b10;
    localparam logic [1:0] OP_STOP      = 2'b11;

    // Bit positions inside cmd_data for a START command.
    localparam int START_DIR_BIT     = 0;
    localparam int START_ONESHOT_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop: Q inverts on a rising clk edge while T is high.
// CLRN clears it asynchronously.
module t_ff_cell (
    input  logic T,
    input  logic clk,
    input  logic CLRN,
    output logic Q
);

    // NOTE: registers use non-blocking (<=) assignments so every flop samples
    // pre-edge values; blocking here would create simulation ordering races.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN)
            Q <= 1'b0;
        else if (T)
            Q <= ~Q;
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Command-driven modulo-(mod+1) up/down counter built on a bank of T cells.
// The controller computes the next value and drives each cell's T with the bits that must flip.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             CLRN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mod_q, mod_nxt;
    logic             dir_q, dir_nxt;
    logic             oneshot_q, oneshot_nxt;
    logic             err_q, err_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] start_val;
    logic             cmd_fire;

    assign cmd_ready = (state != DONE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign terminal  = dir_q ? ZERO : mod_q;
    assign start_val = dir_q ? mod_q : ZERO;
    assign tc        = busy && (count == terminal);

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        mod_nxt     = mod_q;
        dir_nxt     = dir_q;
        oneshot_nxt = oneshot_q;
        err_nxt     = 1'b0;
        count_nxt   = count;

        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_SET_MOD: begin
                            mod_nxt = cmd_data;
                            if (count > cmd_data)
                                count_nxt = cmd_data;
                        end
                        OP_SET_COUNT: begin
                            count_nxt = (cmd_data > mod_q) ? mod_q : cmd_data;
                        end
                        OP_START: begin
                            dir_nxt     = cmd_data[START_DIR_BIT];
                            oneshot_nxt = cmd_data[START_ONESHOT_BIT];
                            state_nxt   = RUN;
                        end
                        default: ;
                    endcase
                end
            end

            RUN: begin
                // STOP wins even on the edge a oneshot would complete.
                if (cmd_fire && cmd_op == OP_STOP) begin
                    state_nxt = IDLE;
                end else begin
                    err_nxt = cmd_fire;
                    if (count != terminal)
                        count_nxt = dir_q ? (count - ONE) : (count + ONE);
                    else if (!oneshot_q)
                        count_nxt = start_val;
                    else
                        state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The cells have no parallel load; every value change is a set of toggles.
    assign t_vec = count ^ count_nxt;

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state     <= IDLE;
            mod_q     <= '1;
            dir_q     <= 1'b0;
            oneshot_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            mod_q     <= mod_nxt;
            dir_q     <= dir_nxt;
            oneshot_q <= oneshot_nxt;
            err_q     <= err_nxt;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .T    (t_vec[i]),
            .clk  (clk),
            .CLRN (CLRN),
            .Q    (count[i])
        );
    end

endmodule
